l2_data_array_mw: RTL and testbench

- Multi-way, parametrised L2 data array with a single request port.
- Request side is a valid/ready handshake. Response side is a registered valid/ready output with backpressure.
- Byte-masked writes. Hardware clear sweep after reset and on demand.
- Sits between the L2 control FSM and the L2 tag/valid logic. Replaces the single-way, combinational-read data array.

---
 rtl/lc3b_types.sv | 22 ++
 rtl/l2_way_bank.sv | 47 ++++
 rtl/l2_data_array_mw.sv | 131 +++++++++++++
 tb/tb_l2_data_array_mw.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared L2 types: geometry constants, data-array FSM states, field typedefs.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lc3b_types;

    // Default L2 geometry
    localparam int L2_WIDTH      = 128;
    localparam int L2_INDEX_BITS = 4;
    localparam int L2_WAYS       = 2;

    // Data-array controller states
    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } l2_arr_state_t;

    typedef logic [L2_INDEX_BITS-1:0]   l2_index_t;
    typedef logic [$clog2(L2_WAYS)-1:0] l2_way_t;
    typedef logic [L2_WIDTH/8-1:0]      l2_mask_t;
    typedef logic [L2_WIDTH-1:0]        l2_line_t;

endpackage

// File: rtl/l2_way_bank.sv
// One way of L2 data storage: flop array with byte-masked write and line clear.
// Latency: write lands on the next rising edge; read is combinational at ridx.
// Backpressure: none; the bank accepts a write every cycle.
//
// Ports:
//   clk           rising-edge clock
//   clr           zero the whole line at widx (wins over we)
//   we            byte-masked write of wdata at widx
//   widx/wmask/wdata  write port
//   ridx/rdata    combinational read port
module l2_way_bank
    import lc3b_types::*;
#(
    parameter int WIDTH      = L2_WIDTH,
    parameter int INDEX_BITS = L2_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [WIDTH/8-1:0]    wmask,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [INDEX_BITS-1:0] ridx,
    output logic [WIDTH-1:0]      rdata
);

    localparam int SETS   = 2**INDEX_BITS;
    localparam int NBYTES = WIDTH/8;

    logic [WIDTH-1:0] mem [SETS];

    // No reset on storage: contents are scrubbed by the controller's sweep.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem[widx] <= '0;
        end else if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wmask[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/l2_data_array_mw.sv
// Multi-way L2 data array: single request port, byte-masked writes, zero sweep.
// Latency: 1 cycle from accepted request to resp_valid (reads and writes alike).
// Backpressure: req_ready drops while a response is held with resp_ready low,
//               during a sweep, and on the cycle clear_req is raised.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset (starts a sweep)
//   clear_req / init_busy      on-demand zero sweep / sweep in progress
//   req_valid/req_ready        request handshake
//   req_write, req_way, req_index, req_wmask, req_wdata   request payload
//   resp_valid/resp_ready      response handshake
//   resp_data                  read line, or merged line after a write
module l2_data_array_mw
    import lc3b_types::*;
#(
    parameter int WIDTH      = L2_WIDTH,
    parameter int INDEX_BITS = L2_INDEX_BITS,
    parameter int WAYS       = L2_WAYS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_req,
    output logic                    init_busy,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [$clog2(WAYS)-1:0] req_way,
    input  logic [INDEX_BITS-1:0]   req_index,
    input  logic [WIDTH/8-1:0]      req_wmask,
    input  logic [WIDTH-1:0]        req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WIDTH-1:0]        resp_data
);

    localparam int WB     = $clog2(WAYS);
    localparam int NBYTES = WIDTH/8;
    localparam logic [INDEX_BITS-1:0] LAST_SET = '1;

    l2_arr_state_t         state;
    logic [INDEX_BITS-1:0] sweep_cnt;

    logic                  sweeping;
    logic                  accept;
    logic [INDEX_BITS-1:0] bank_widx;
    logic [WAYS-1:0]       way_we;
    logic [WIDTH-1:0]      rd_line [WAYS];
    logic [WIDTH-1:0]      rd_sel;
    logic [WIDTH-1:0]      merged;

    assign sweeping  = (state == SWEEP);
    assign init_busy = sweeping;

    // Accept only when idle, no clear is being requested, and the output
    // register is empty or draining this cycle.
    assign req_ready = !sweeping && !clear_req && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    // During a sweep the write port is owned by the sweep counter.
    assign bank_widx = sweeping ? sweep_cnt : req_index;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_we[w] = accept && req_write && (req_way == WB'(w));

        l2_way_bank #(
            .WIDTH      (WIDTH),
            .INDEX_BITS (INDEX_BITS)
        ) u_bank (
            .clk   (clk),
            .clr   (sweeping),
            .we    (way_we[w]),
            .widx  (bank_widx),
            .wmask (req_wmask),
            .wdata (req_wdata),
            .ridx  (req_index),
            .rdata (rd_line[w])
        );
    end

    assign rd_sel = rd_line[req_way];

    // Merged line = what the bank will hold after this write; it is also the
    // write response, so the response never has to re-read storage.
    always_comb begin
        merged = rd_sel;
        for (int b = 0; b < NBYTES; b++) begin
            if (req_wmask[b]) begin
                merged[8*b +: 8] = req_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SWEEP;
            sweep_cnt  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            case (state)
                SWEEP: begin
                    sweep_cnt <= sweep_cnt + INDEX_BITS'(1);
                    if (sweep_cnt == LAST_SET) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state     <= SWEEP;
                        sweep_cnt <= '0;
                    end
                end
                default: begin
                    state     <= SWEEP;
                    sweep_cnt <= '0;
                end
            endcase

            // A held response keeps draining while a sweep runs; accept is
            // never true during a sweep, so only the drain branch applies.
            if (accept) begin
                resp_valid <= 1'b1;
                resp_data  <= req_write ? merged : rd_sel;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
                resp_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_l2_data_array_mw.sv
// Directed bench for l2_data_array_mw with a line-level reference model.
module tb_l2_data_array_mw;

    localparam int W    = 128;
    localparam int WAYS = 2;
    localparam int SETS = 16;
    localparam int NB   = W/8;

    localparam logic [W-1:0] FULL   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [W-1:0] AAAA   = {16{8'hAA}};
    localparam logic [W-1:0] MERGED = {{12{8'hAA}}, 32'hFFFF_FFFF};

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          clear_req  = 1'b0;
    logic          req_valid  = 1'b0;
    logic          req_write  = 1'b0;
    logic [0:0]    req_way    = '0;
    logic [3:0]    req_index  = '0;
    logic [NB-1:0] req_wmask  = '0;
    logic [W-1:0]  req_wdata  = '0;
    logic          resp_ready = 1'b1;
    logic          init_busy;
    logic          req_ready;
    logic          resp_valid;
    logic [W-1:0]  resp_data;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    l2_data_array_mw #(.WIDTH(W), .INDEX_BITS(4), .WAYS(WAYS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .init_busy  (init_busy),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_way    (req_way),
        .req_index  (req_index),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole array is considered zero from the moment a
    // sweep starts; m_left counts the cycles the array stays unavailable.
    logic [W-1:0] mdl [WAYS][SETS];
    int           m_left  = SETS;
    bit           m_busy  = 1'b1;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    bit           m_acc;
    logic [W-1:0] m_line;

    function automatic bit m_ready();
        return !m_busy && !clear_req && (!m_valid || resp_ready);
    endfunction

    task automatic m_zero();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                mdl[w][s] = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b1;
            m_left  = SETS;
            m_valid = 1'b0;
            m_data  = '0;
            m_zero();
        end else begin
            m_acc = req_valid && m_ready();
            if (m_acc) begin
                m_line = mdl[req_way][req_index];
                if (req_write) begin
                    for (int b = 0; b < NB; b++)
                        if (req_wmask[b]) m_line[8*b +: 8] = req_wdata[8*b +: 8];
                    mdl[req_way][req_index] = m_line;
                end
                m_valid = 1'b1;
                m_data  = m_line;
            end else if (resp_ready) begin
                m_valid = 1'b0;
                m_data  = '0;
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end else if (clear_req) begin
                m_zero();
                m_busy = 1'b1;
                m_left = SETS;
            end
        end
    end

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("init_busy",  W'(init_busy),  W'(m_busy));
            chk("req_ready",  W'(req_ready),  W'(m_ready()));
            chk("resp_valid", W'(resp_valid), W'(m_valid));
            if (m_valid) chk("resp_data", resp_data, m_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit wr, input logic [0:0] way, input logic [3:0] idx,
                          input logic [NB-1:0] mask, input logic [W-1:0] data);
        req_valid = 1'b1;
        req_write = wr;
        req_way   = way;
        req_index = idx;
        req_wmask = mask;
        req_wdata = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("accept_timeout", W'(req_ready), W'(1));
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        cyc();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (init_busy) n++;
            else break;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!init_busy) break;
        end
        chk("sweep_done", W'(init_busy), W'(0));
    endtask

    task automatic read_all();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                do_req(1'b0, 1'(w), 4'(s), '0, '0);
    endtask

    int n;

    initial begin
        // Reset with a read already waiting on the request port
        req_valid = 1'b1;
        #2 rst_n = 1'b0;
        check_en = 1'b1;
        #1;
        chk("rst_resp_valid", W'(resp_valid), W'(0));
        chk("rst_resp_data",  resp_data,      '0);
        chk("rst_init_busy",  W'(init_busy),  W'(1));
        chk("rst_req_ready",  W'(req_ready),  W'(0));
        #3 rst_n = 1'b1;
        count_busy(n);
        chk("reset_sweep_len", W'(n), W'(16));
        cyc();
        req_valid = 1'b0;
        chk("first_read_valid", W'(resp_valid), W'(1));
        chk("first_read_data",  resp_data,      '0);
        read_all();
        chk("after_sweep_w1s15", resp_data, '0);

        // Full-mask write then read back, other way untouched
        do_req(1'b1, 1'b1, 4'd5, '1, FULL);
        chk("full_write_resp", resp_data, FULL);
        do_req(1'b0, 1'b1, 4'd5, '0, '0);
        chk("full_read_w1s5", resp_data, FULL);
        do_req(1'b0, 1'b0, 4'd5, '0, '0);
        chk("read_w0s5", resp_data, '0);

        // Partial write over an AA line
        do_req(1'b1, 1'b0, 4'd3, '1, AAAA);
        do_req(1'b1, 1'b0, 4'd3, 16'h000F, '1);
        chk("partial_write_resp", resp_data, MERGED);
        do_req(1'b0, 1'b0, 4'd3, '0, '0);
        chk("partial_read", resp_data, MERGED);
        // Zero-mask write: responds, storage unchanged
        do_req(1'b1, 1'b0, 4'd3, '0, '1);
        chk("zero_mask_resp", resp_data, MERGED);

        // Backpressure
        drain();
        chk("drained", W'(resp_valid), W'(0));
        resp_ready = 1'b0;
        do_req(1'b0, 1'b1, 4'd5, '0, '0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_way   = 1'b0;
        req_index = 4'd3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_valid_held", W'(resp_valid), W'(1));
            chk("bp_data_stable", resp_data, FULL);
            chk("bp_req_ready", W'(req_ready), W'(0));
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", W'(req_ready), W'(1));
        cyc();
        req_valid = 1'b0;
        chk("bp_b2b_data", resp_data, MERGED);

        // Clear with a pending response and a competing write
        drain();
        resp_ready = 1'b0;
        do_req(1'b0, 1'b1, 4'd5, '0, '0);
        clear_req = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_way   = 1'b1;
        req_index = 4'd5;
        req_wmask = '1;
        req_wdata = '1;
        #1;
        chk("clear_blocks_req", W'(req_ready), W'(0));
        cyc();
        clear_req = 1'b0;
        req_valid = 1'b0;
        chk("clear_pending_valid", W'(resp_valid), W'(1));
        chk("clear_pending_data",  resp_data,      FULL);
        chk("clear_busy",          W'(init_busy),  W'(1));
        resp_ready = 1'b1;
        cyc();
        chk("clear_drained", W'(resp_valid), W'(0));
        wait_idle();
        read_all();
        do_req(1'b0, 1'b1, 4'd5, '0, '0);
        chk("clear_w1s5_zero", resp_data, '0);

        // Reset with a response pending
        drain();
        resp_ready = 1'b0;
        do_req(1'b0, 1'b0, 4'd3, '0, '0);
        chk("pre_rst_pending", W'(resp_valid), W'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drops_resp", W'(resp_valid), W'(0));
        chk("rst_busy",       W'(init_busy),  W'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        resp_ready = 1'b1;
        count_busy(n);
        chk("rst_pending_sweep_len", W'(n), W'(16));

        // Reset in the middle of a sweep
        cyc();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (5) cyc();
        chk("mid_sweep_busy", W'(init_busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_sweep_rst_valid", W'(resp_valid), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy(n);
        chk("mid_sweep_restart_len", W'(n), W'(16));
        do_req(1'b0, 1'b0, 4'd3, '0, '0);
        chk("post_rst_zero", resp_data, '0);

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
